// File: rtl/letc_sram_responder_pkg.sv
// letc_sram_responder_pkg
//   Shared types and helpers for the on-chip SRAM responder.
//   - word_t / wmask_t  : bus word and byte-strobe types
//   - sram_rsp_state_e  : responder FSM states
//   - WORD_BYTES        : bytes per bus word
//   - addr_fault()      : range/alignment decode for a byte address
package letc_sram_responder_pkg;

    localparam int WORD_BYTES = 4;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  wmask_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } sram_rsp_state_e;

    // Fault when the address is below the window, at/above its end, or not
    // word aligned. Compared in 33 bits so a window ending at 2^32 still works.
    function automatic logic addr_fault(word_t addr, word_t base, int unsigned span_bytes);
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + 33'(span_bytes);
        return (a < lo) || (a >= hi) || (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/letc_sram_responder_if.sv
// letc_sram_responder_if
//   Memory request/response channel between an initiator (master) and the
//   SRAM responder (slave).
//   req_valid/req_ready/req_addr/req_wen/req_wdata/req_wmask : request channel
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err                    : response channel
interface letc_sram_responder_if;
    import letc_sram_responder_pkg::*;

    logic   req_valid;
    logic   req_ready;
    word_t  req_addr;
    logic   req_wen;
    word_t  req_wdata;
    wmask_t req_wmask;
    logic   rsp_valid;
    logic   rsp_ready;
    word_t  rsp_rdata;
    logic   rsp_err;

    modport master (
        output req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/letc_sram_bank.sv
// letc_sram_bank
//   Single-port synchronous SRAM with per-byte write enables. No reset.
//   clk   : clock
//   en    : access enable for this cycle
//   wen   : 1 = write the strobed bytes, 0 = read
//   wmask : byte strobes, bit i -> wdata[8i+7:8i]
//   index : word index
//   wdata : write data
//   rdata : read data, valid on the edge after en (old contents on a write)
module letc_sram_bank
    import letc_sram_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             wen,
    input  wmask_t           wmask,
    input  logic [IDX_W-1:0] index,
    input  word_t            wdata,
    output wire word_t       rdata
);

    // One byte-wide array per lane keeps each lane a plain inferable RAM.
    genvar gi;
    generate
        for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
            logic [7:0] mem [DEPTH_WORDS];
            logic [7:0] rdata_reg;

            always_ff @(posedge clk) begin
                if (en) begin
                    if (wen && wmask[gi]) begin
                        mem[index] <= wdata[8*gi +: 8];
                    end
                    rdata_reg <= mem[index];
                end
            end

            assign rdata[8*gi +: 8] = rdata_reg;
        end
    endgenerate

endmodule

// File: rtl/letc_sram_responder.sv
// letc_sram_responder
//   Target end of the memory request/response bus: accepts one word read or
//   write at a time, services it from an internal SRAM after WAIT_STATES
//   extra cycles and returns data or an access fault.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : letc_sram_responder_if.slave (request and response channels)
//   Optional (LETC_SRAM_RESPONDER_STATS_EN defined):
//   stat_reads / stat_writes : counts of completed non-error reads / writes
module letc_sram_responder
    import letc_sram_responder_pkg::*;
#(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    WAIT_STATES = 1,
    parameter word_t BASE_ADDR   = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    letc_sram_responder_if.slave    bus
`ifdef LETC_SRAM_RESPONDER_STATS_EN
    ,
    output word_t                   stat_reads,
    output word_t                   stat_writes
`endif
);

    localparam int          IDX_W      = $clog2(DEPTH_WORDS);
    localparam int unsigned SPAN_BYTES = WORD_BYTES * DEPTH_WORDS;
    localparam logic [3:0]  WAIT_INIT  = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    sram_rsp_state_e  state_reg,     state_next;
    logic [3:0]       wait_cnt_reg,  wait_cnt_next;
    logic [IDX_W-1:0] index_reg,     index_next;
    logic             wen_reg,       wen_next;
    word_t            wdata_reg,     wdata_next;
    wmask_t           wmask_reg,     wmask_next;
    logic             err_reg,       err_next;
    logic             req_ready_reg, req_ready_next;
    logic             rsp_valid_reg, rsp_valid_next;
    word_t            rsp_rdata_reg, rsp_rdata_next;
    logic             rsp_err_reg,   rsp_err_next;

    logic  bank_en;
    word_t bank_rdata;

    letc_sram_bank #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_bank (
        .clk   (clk),
        .en    (bank_en),
        .wen   (wen_reg),
        .wmask (wmask_reg),
        .index (index_reg),
        .wdata (wdata_reg),
        .rdata (bank_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            wait_cnt_reg  <= '0;
            index_reg     <= '0;
            wen_reg       <= 1'b0;
            wdata_reg     <= '0;
            wmask_reg     <= '0;
            err_reg       <= 1'b0;
            req_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            index_reg     <= index_next;
            wen_reg       <= wen_next;
            wdata_reg     <= wdata_next;
            wmask_reg     <= wmask_next;
            err_reg       <= err_next;
            req_ready_reg <= req_ready_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= rsp_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        wait_cnt_next  = wait_cnt_reg;
        index_next     = index_reg;
        wen_next       = wen_reg;
        wdata_next     = wdata_reg;
        wmask_next     = wmask_reg;
        err_next       = err_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_err_next   = rsp_err_reg;
        bank_en        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.req_valid && req_ready_reg) begin
                    index_next = IDX_W'((bus.req_addr - BASE_ADDR) >> 2);
                    wen_next   = bus.req_wen;
                    wdata_next = bus.req_wdata;
                    wmask_next = bus.req_wmask;
                    err_next   = addr_fault(bus.req_addr, BASE_ADDR, SPAN_BYTES);
                    if (WAIT_STATES == 0) begin
                        state_next = ACCESS;
                    end else begin
                        state_next    = WAIT;
                        wait_cnt_next = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt_reg == 4'd0) begin
                    state_next = ACCESS;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                end
            end
            ACCESS: begin
                // A faulting access never touches the array.
                bank_en    = !err_reg;
                state_next = RESP;
            end
            RESP: begin
                // First RESP cycle captures the bank output into the response
                // registers; they then hold until the initiator takes them.
                if (!rsp_valid_reg) begin
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = err_reg;
                    rsp_rdata_next = (err_reg || wen_reg) ? '0 : bank_rdata;
                end else if (bus.rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    rsp_rdata_next = '0;
                    rsp_err_next   = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        req_ready_next = (state_next == IDLE);
    end

    assign bus.req_ready = req_ready_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_rdata = rsp_rdata_reg;
    assign bus.rsp_err   = rsp_err_reg;

`ifdef LETC_SRAM_RESPONDER_STATS_EN
    word_t stat_reads_reg;
    word_t stat_writes_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_reads_reg  <= '0;
            stat_writes_reg <= '0;
        end else if (rsp_valid_reg && bus.rsp_ready && !rsp_err_reg) begin
            if (wen_reg) begin
                stat_writes_reg <= stat_writes_reg + 32'd1;
            end else begin
                stat_reads_reg  <= stat_reads_reg + 32'd1;
            end
        end
    end

    assign stat_reads  = stat_reads_reg;
    assign stat_writes = stat_writes_reg;
`endif

endmodule

// File: tb/tb_letc_sram_responder.sv
// tb_letc_sram_responder
//   Randomized scoreboard bench for letc_sram_responder. A main DUT with three
//   wait states carries the scoreboard traffic; a second DUT with zero wait
//   states gets a short directed latency/data sequence.
module tb_letc_sram_responder;
    import letc_sram_responder_pkg::*;

    localparam int    DEPTH = 64;
    localparam int    WS    = 3;
    localparam word_t BASE  = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    letc_sram_responder_if bus ();
    letc_sram_responder_if bus0 ();

`ifdef LETC_SRAM_RESPONDER_STATS_EN
    word_t stat_reads, stat_writes, stat0_reads, stat0_writes;
`endif

    letc_sram_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS), .BASE_ADDR(BASE)) u_dut (
        .clk (clk), .rst (rst), .bus (bus)
`ifdef LETC_SRAM_RESPONDER_STATS_EN
        , .stat_reads (stat_reads), .stat_writes (stat_writes)
`endif
    );

    letc_sram_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .BASE_ADDR(BASE)) u_dut0 (
        .clk (clk), .rst (rst), .bus (bus0)
`ifdef LETC_SRAM_RESPONDER_STATS_EN
        , .stat_reads (stat0_reads), .stat_writes (stat0_writes)
`endif
    );

    typedef struct {
        word_t rdata;
        logic  err;
        logic  wen;
    } exp_t;

    exp_t  sb_q[$];
    int    acc_q[$];
    word_t ref_mem [DEPTH];
    int    rdy_mode   = 0;   // 0 random, 1 hold low, 2 hold high
    int    exp_reads  = 0;
    int    exp_writes = 0;
    int    tests = 0;
    int    fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // Reference model: address window rule plus a byte-wise memory update.
    function automatic exp_t model(word_t addr, logic wen, word_t wdata, wmask_t m);
        exp_t   e;
        longint a;
        bit     ok;
        int     idx;
        a  = longint'(addr);
        ok = (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * DEPTH) && (a % 4 == 0);
        e.wen   = wen;
        e.err   = !ok;
        e.rdata = '0;
        if (ok) begin
            idx = int'((a - longint'(BASE)) / 4);
            if (wen) begin
                for (int b = 0; b < 4; b++) begin
                    if (m[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
                end
            end else begin
                e.rdata = ref_mem[idx];
            end
        end
        return e;
    endfunction

    // Issue one request on the main DUT. With drop set, the transaction is
    // expected to be killed by reset, so nothing is scored or modelled.
    task automatic do_req(input word_t addr, input logic wen, input word_t wdata,
                          input wmask_t m, input bit drop, output int acc);
        exp_t e;
        acc = -1;
        @(negedge clk);
        bus.req_addr  = addr;
        bus.req_wen   = wen;
        bus.req_wdata = wdata;
        bus.req_wmask = m;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (bus.req_ready) begin
                acc = cyc + 1;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) begin
            fail_now("req_accept_timeout");
            bus.req_valid = 1'b0;
            return;
        end
        if (!drop) begin
            e = model(addr, wen, wdata, m);
            sb_q.push_back(e);
            acc_q.push_back(acc);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && acc_q.size() == 0 && !bus.rsp_valid) begin
                done = 1;
                break;
            end
        end
        if (!done) fail_now("drain_timeout");
    endtask

    task automatic x0(input word_t addr, input logic wen, input word_t wdata, input wmask_t m,
                      output word_t rd, output logic er, output int lat);
        int acc = -1;
        lat = -1;
        rd  = '0;
        er  = 1'b0;
        @(negedge clk);
        bus0.req_addr  = addr;
        bus0.req_wen   = wen;
        bus0.req_wdata = wdata;
        bus0.req_wmask = m;
        bus0.req_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (bus0.req_ready) begin
                acc = cyc + 1;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) begin
            fail_now("ws0_accept_timeout");
            bus0.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus0.req_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus0.rsp_valid) begin
                lat = cyc - acc;
                rd  = bus0.rsp_rdata;
                er  = bus0.rsp_err;
                break;
            end
        end
        if (lat < 0) fail_now("ws0_rsp_timeout");
        @(posedge clk);
        #1;
    endtask

    // Monitor: drives rsp_ready for the coming edge, then scores any
    // response that will be taken at that edge.
    initial begin : monitor
        bit   prev = 0;
        exp_t e;
        int   a;
        int   n = 0;
        bus.rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                1:       bus.rsp_ready = 1'b0;
                2:       bus.rsp_ready = 1'b1;
                default: bus.rsp_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (rst) begin
                prev = 0;
                continue;
            end
            if (bus.rsp_valid && !prev) begin
                if (acc_q.size() == 0) begin
                    fail_now("unexpected_rsp_valid");
                end else begin
                    a = acc_q.pop_front();
                    chk("latency", 64'(cyc - a), 64'(2 + WS));
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (sb_q.size() == 0) begin
                    fail_now("rsp_without_request");
                end else begin
                    e = sb_q.pop_front();
                    n++;
                    $display("[TB] rsp %0d wen=%0b rdata=%08h err=%0b (expect %08h/%0b)",
                             n, e.wen, bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
                    chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
                    chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
                    if (!e.err) begin
                        if (e.wen) exp_writes++;
                        else       exp_reads++;
                    end
                end
            end
            prev = bus.rsp_valid && !bus.rsp_ready;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic reset_pulse_and_check(input string tag);
        rst = 1'b1;
        exp_reads  = 0;
        exp_writes = 0;
        #1;
        chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'(0));
        chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
        chk({tag, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'(0));
        chk({tag, "_rsp_err"},   64'(bus.rsp_err),   64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_ready_after_release"}, 64'(bus.req_ready), 64'(1));
    endtask

    initial begin : main
        int    acc;
        word_t rd, cap_rd;
        logic  er, cap_er;
        int    lat;
        bit    seen;
        word_t addr;
        int    r;

        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_wen = 1'b0;
        bus.req_wdata = '0;   bus.req_wmask = '0;
        bus0.req_valid = 1'b0; bus0.req_addr = '0; bus0.req_wen = 1'b0;
        bus0.req_wdata = '0;   bus0.req_wmask = '0; bus0.rsp_ready = 1'b1;

        // Power-on reset
        repeat (2) @(negedge clk);
        chk("por_req_ready", 64'(bus.req_ready), 64'(0));
        chk("por_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("por_ready_after_release", 64'(bus.req_ready), 64'(1));

        // Fill every word so later reads have defined contents.
        for (int i = 0; i < DEPTH; i++) do_req(BASE + 32'(4 * i), 1'b1, $urandom, 4'hF, 1'b0, acc);

        // Write/read back and byte strobes on the main DUT (scored by the model).
        do_req(BASE + 32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0, acc);
        do_req(BASE + 32'h10, 1'b0, 32'h0, 4'h0, 1'b0, acc);
        do_req(BASE + 32'h14, 1'b1, 32'h1122_3344, 4'hF, 1'b0, acc);
        do_req(BASE + 32'h14, 1'b1, 32'hAABB_CCDD, 4'b0101, 1'b0, acc);
        do_req(BASE + 32'h14, 1'b0, 32'h0, 4'h0, 1'b0, acc);
        do_req(BASE + 32'h14, 1'b1, 32'hFFFF_FFFF, 4'h0, 1'b0, acc);
        do_req(BASE + 32'h14, 1'b0, 32'h0, 4'h0, 1'b0, acc);

        // Faults, then word 0 read back.
        do_req(BASE + 32'(4 * DEPTH), 1'b1, 32'h1234_5678, 4'hF, 1'b0, acc);
        do_req(BASE - 32'd4, 1'b0, 32'h0, 4'h0, 1'b0, acc);
        do_req(BASE + 32'h2, 1'b1, 32'h8765_4321, 4'hF, 1'b0, acc);
        do_req(BASE, 1'b0, 32'h0, 4'h0, 1'b0, acc);
        do_req(BASE + 32'(4 * (DEPTH - 1)), 1'b0, 32'h0, 4'h0, 1'b0, acc);

        // Zero-wait-state instance: latency and data with explicit constants.
        x0(BASE + 32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
        chk("ws0_write_latency", 64'(lat), 64'(2));
        chk("ws0_write_err", 64'(er), 64'(0));
        chk("ws0_write_rdata", 64'(rd), 64'(0));
        x0(BASE + 32'h10, 1'b0, 32'h0, 4'h0, rd, er, lat);
        chk("ws0_read_latency", 64'(lat), 64'(2));
        chk("ws0_read_rdata", 64'(rd), 64'(32'hDEAD_BEEF));
        chk("ws0_read_err", 64'(er), 64'(0));
        x0(BASE + 32'h18, 1'b1, 32'h1122_3344, 4'hF, rd, er, lat);
        x0(BASE + 32'h18, 1'b1, 32'hAABB_CCDD, 4'b0101, rd, er, lat);
        x0(BASE + 32'h18, 1'b0, 32'h0, 4'h0, rd, er, lat);
        chk("ws0_strobe_rdata", 64'(rd), 64'(32'h11BB_33DD));
        x0(BASE - 32'd4, 1'b0, 32'h0, 4'h0, rd, er, lat);
        chk("ws0_fault_err", 64'(er), 64'(1));
        chk("ws0_fault_rdata", 64'(rd), 64'(0));
        chk("ws0_fault_latency", 64'(lat), 64'(2));

        // Backpressure: response held stable while rsp_ready stays low.
        wait_idle();
        rdy_mode = 1;
        do_req(BASE + 32'h10, 1'b0, 32'h0, 4'h0, 1'b0, acc);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                seen = 1;
                break;
            end
        end
        if (!seen) fail_now("bp_rsp_timeout");
        cap_rd = bus.rsp_rdata;
        cap_er = bus.rsp_err;
        chk("bp_rdata_value", 64'(cap_rd), 64'(32'hDEAD_BEEF));
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid_held", 64'(bus.rsp_valid), 64'(1));
            chk("bp_rdata_stable", 64'(bus.rsp_rdata), 64'(cap_rd));
            chk("bp_err_stable", 64'(bus.rsp_err), 64'(cap_er));
            chk("bp_req_ready_low", 64'(bus.req_ready), 64'(0));
        end
        #1;
        rdy_mode = 2;
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("bp_valid_dropped", 64'(bus.rsp_valid), 64'(0));
        chk("bp_ready_after_rsp", 64'(bus.req_ready), 64'(1));
        rdy_mode = 0;

        // Reset while a read is in WAIT: transaction dropped.
        wait_idle();
        do_req(BASE + 32'h30, 1'b0, 32'h0, 4'h0, 1'b1, acc);
        while (cyc != acc + 1) @(negedge clk);
        reset_pulse_and_check("rst_wait");
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1;
        end
        chk("rst_wait_no_rsp", 64'(seen), 64'(0));

        // Reset while a write is in ACCESS: write must not land.
        do_req(BASE + 32'h20, 1'b1, ~ref_mem[8], 4'hF, 1'b1, acc);
        while (cyc != acc + WS) @(negedge clk);
        reset_pulse_and_check("rst_access");
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1;
        end
        chk("rst_access_no_rsp", 64'(seen), 64'(0));
        do_req(BASE + 32'h20, 1'b0, 32'h0, 4'h0, 1'b0, acc);

        // Randomized traffic with random response backpressure.
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            else if (r == 7) addr = ($urandom_range(0, 1) == 1) ? BASE + 32'(4 * (DEPTH + $urandom_range(0, 3)))
                                                                 : BASE - 32'(4 * $urandom_range(1, 4));
            else if (r == 8) addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
            else             addr = BASE + 32'(4 * (DEPTH - 1));
            do_req(addr, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), 1'b0, acc);
        end
        wait_idle();

`ifdef LETC_SRAM_RESPONDER_STATS_EN
        chk("stat_reads", 64'(stat_reads), 64'(exp_reads));
        chk("stat_writes", 64'(stat_writes), 64'(exp_writes));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
